// File: rtl/clk_en_divider.sv
// Fractional clock-enable synthesizer: a phase accumulator emits single-cycle ce pulses at an
// average rate of CLK*MUL/DIV, with req/ack run-time reconfiguration and a lock indicator.
module clk_en_divider #(
    parameter int ACC_W       = 8,
    parameter int DEF_MUL     = 5,
    parameter int DEF_DIV     = 6,
    parameter int LOCK_PULSES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run,
    input  logic [ACC_W-1:0] cfg_mul,
    input  logic [ACC_W-1:0] cfg_div,
    input  logic             cfg_req,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             ce,
    output logic             ce_half,
    output logic             locked
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ACK,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_mul;
    logic [ACC_W-1:0] r_div;
    logic [ACC_W-1:0] r_req_mul;
    logic [ACC_W-1:0] r_req_div;
    logic             r_ce;
    logic             r_ce_half;
    logic             r_locked;
    logic             r_cfg_ack;
    logic             r_cfg_err;
    logic [15:0]      r_lock_cnt;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_sum_sub;
    logic             w_ovf;
    logic             w_cfg_valid;
    logic             w_apply;
    logic             w_ce_next;
    logic [15:0]      w_lock_cnt_next;

    // MUL <= DIV keeps acc < DIV, so the ACC_W+1 bit sum never overflows.
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_mul};
    assign w_sum_sub   = w_sum - {1'b0, r_div};
    assign w_ovf       = (w_sum >= {1'b0, r_div});
    assign w_cfg_valid = (r_req_mul != '0) && (r_req_div != '0) && (r_req_mul <= r_req_div);
    assign w_apply     = (r_state == S_CHECK) && w_cfg_valid;
    assign w_ce_next   = !w_apply && run && w_ovf;

    assign w_lock_cnt_next = (r_ce && (r_lock_cnt != 16'hFFFF)) ? r_lock_cnt + 16'd1 : r_lock_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc      <= '0;
            r_mul      <= ACC_W'(DEF_MUL);
            r_div      <= ACC_W'(DEF_DIV);
            r_ce       <= 1'b0;
            r_ce_half  <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_ce      <= w_ce_next;
            r_ce_half <= r_ce_half ^ w_ce_next;
            if (w_apply) begin
                r_mul <= r_req_mul;
                r_div <= r_req_div;
                r_acc <= '0;
            end else if (run) begin
                r_acc <= w_ovf ? w_sum_sub[ACC_W-1:0] : w_sum[ACC_W-1:0];
            end
            if (w_apply || !run) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                r_lock_cnt <= w_lock_cnt_next;
                r_locked   <= (w_lock_cnt_next >= 16'(LOCK_PULSES));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_req_mul <= '0;
            r_req_div <= '0;
            r_cfg_ack <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            // NOTE: these defaults are overridden by the later non-blocking writes in S_CHECK,
            // which is what makes cfg_ack a single-cycle pulse without extra state.
            r_cfg_ack <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_req) begin
                        r_req_mul <= cfg_mul;
                        r_req_div <= cfg_div;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_cfg_ack <= 1'b1;
                    r_cfg_err <= !w_cfg_valid;
                    r_state   <= S_ACK;
                end
                S_ACK: r_state <= S_WAIT;
                S_WAIT: begin
                    if (!cfg_req) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ack = r_cfg_ack;
    assign cfg_err = r_cfg_err;
    assign ce      = r_ce;
    assign ce_half = r_ce_half;
    assign locked  = r_locked;

endmodule

// File: tb/tb_clk_en_divider.sv
// Self-checking bench for clk_en_divider: closed-form rate model checked every cycle,
// a table of configuration requests, hand-written corner sequences and a random phase.
module tb_clk_en_divider;

    localparam int LOCK = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       run = 1'b0;
    logic       cfg_req = 1'b0;
    logic [7:0] cfg_mul = 8'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ack, cfg_err, ce, ce_half, locked;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clk_en_divider #(
        .ACC_W      (8),
        .DEF_MUL    (5),
        .DEF_DIV    (6),
        .LOCK_PULSES(LOCK)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .run    (run),
        .cfg_mul(cfg_mul),
        .cfg_div(cfg_div),
        .cfg_req(cfg_req),
        .cfg_ack(cfg_ack),
        .cfg_err(cfg_err),
        .ce     (ce),
        .ce_half(ce_half),
        .locked (locked)
    );

    always #5 CLK = ~CLK;

    // Reference model: ce at accumulate step k (counted from the last acc clear) is
    // floor(k*MUL/DIV) - floor((k-1)*MUL/DIV); handshake tracked by age since latch.
    longint m_k;
    int     m_mul, m_div, m_cnt;
    bit     m_ce, m_half, m_locked, m_ack, m_err;
    int     hs_age;
    int     h_mul, h_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit apply;
        bit valid;
        bit next_ce;
        apply = 1'b0;
        if (RST) begin
            m_k = 0; m_mul = 5; m_div = 6; m_cnt = 0;
            m_ce = 0; m_half = 0; m_locked = 0; m_ack = 0; m_err = 0;
            hs_age = -1;
            return;
        end
        m_ack = 0;
        m_err = 0;
        case (hs_age)
            -1: if (cfg_req) begin h_mul = cfg_mul; h_div = cfg_div; hs_age = 0; end
            0: begin
                valid  = (h_mul >= 1) && (h_div >= 1) && (h_mul <= h_div);
                apply  = valid;
                m_ack  = 1;
                m_err  = !valid;
                hs_age = 1;
            end
            1: hs_age = 2;
            default: if (!cfg_req) hs_age = -1;
        endcase
        if (apply || !run) begin
            m_cnt = 0;
            m_locked = 0;
        end else begin
            if (m_ce && m_cnt < 65535) m_cnt++;
            m_locked = (m_cnt >= LOCK);
        end
        if (apply) begin
            m_k = 0; m_mul = h_mul; m_div = h_div; next_ce = 0;
        end else if (run) begin
            m_k++;
            next_ce = ((m_k * m_mul) / m_div) != (((m_k - 1) * m_mul) / m_div);
        end else begin
            next_ce = 0;
        end
        m_ce   = next_ce;
        m_half = m_half ^ next_ce;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        check("ce", ce, m_ce);
        check("ce_half", ce_half, m_half);
        check("locked", locked, m_locked);
        check("cfg_ack", cfg_ack, m_ack);
        check("cfg_err", cfg_err, m_err);
    endtask

    task automatic do_cfg(input logic [7:0] mul, input logic [7:0] div,
                          output bit got_err, output int lat);
        cfg_mul = mul; cfg_div = div; cfg_req = 1'b1;
        lat = 0; got_err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (cfg_ack === 1'b1) begin lat = i; got_err = cfg_err; break; end
        end
        cfg_req = 1'b0;
        cfg_mul = 8'($urandom);
        cfg_div = 8'($urandom);
        step();
        step();
    endtask

    task automatic wait_ce(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (ce === 1'b1) begin n = i; break; end
        end
    endtask

    // Starting from acc=0 with 5/6: ce pattern 0,1,1,1,1,1 repeating.
    task automatic check_default_pattern();
        int   n_ce;
        int   n_tog;
        logic prev_half;
        n_ce = 0; n_tog = 0;
        run = 1'b1;
        prev_half = ce_half;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) check("pat_step1_ce", ce, 0);
            if (i == 2) check("pat_step2_ce", ce, 1);
            if (ce === 1'b1) n_ce++;
            if (ce_half !== prev_half) n_tog++;
            prev_half = ce_half;
        end
        check("pat_ce_count_12", n_ce, 10);
        check("pat_half_toggles_12", n_tog, 10);
    endtask

    typedef struct {
        logic [7:0] mul;
        logic [7:0] div;
        bit         err;
    } cfg_vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_vec_t vecs[9];
        bit   got_err;
        int   lat, n, n_acks, n_ce;
        int   m, d;
        bit   seen_ack;

        vecs[0] = '{8'd25,  8'd16,  1'b1};
        vecs[1] = '{8'd0,   8'd6,   1'b1};
        vecs[2] = '{8'd3,   8'd0,   1'b1};
        vecs[3] = '{8'd0,   8'd0,   1'b1};
        vecs[4] = '{8'd200, 8'd100, 1'b1};
        vecs[5] = '{8'd255, 8'd255, 1'b0};
        vecs[6] = '{8'd1,   8'd255, 1'b0};
        vecs[7] = '{8'd5,   8'd6,   1'b0};
        vecs[8] = '{8'd9,   8'd10,  1'b0};

        // Reset state
        RST = 1'b1;
        step();
        step();
        check("rst_ce", ce, 0);
        check("rst_ce_half", ce_half, 0);
        check("rst_locked", locked, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        RST = 1'b0;
        step();

        // Default 5/6 rate from acc=0
        check_default_pattern();

        // Request table: latency, error flag, rate continuity via the model
        foreach (vecs[i]) begin
            do_cfg(vecs[i].mul, vecs[i].div, got_err, lat);
            check("tbl_ack_latency", lat, 2);
            check("tbl_cfg_err", got_err, vecs[i].err);
            for (int j = 0; j < 6; j++) step();
        end

        // Apply 1/4 while locked: lock drops, period 4, relock after 16 ce
        for (int j = 0; j < 30; j++) step();
        check("pre14_locked", locked, 1);
        cfg_mul = 8'd1; cfg_div = 8'd4; cfg_req = 1'b1;
        step();
        step();
        cfg_req = 1'b0;
        check("a14_ack", cfg_ack, 1);
        check("a14_err", cfg_err, 0);
        check("a14_locked_drop", locked, 0);
        wait_ce(10, n);
        check("a14_first_ce_steps", n, 4);
        wait_ce(10, n);
        check("a14_period", n, 4);
        n_ce = 2;
        for (int j = 0; j < 200; j++) begin
            step();
            if (locked === 1'b1) break;
            if (ce === 1'b1) n_ce++;
        end
        check("a14_locked_rise", locked, 1);
        check("a14_ce_before_lock", n_ce, LOCK);

        // 7/7: continuous ce; run=0 freezes and clears lock
        do_cfg(8'd7, 8'd7, got_err, lat);
        check("a77_err", got_err, 0);
        for (int j = 0; j < 20; j++) step();
        check("a77_ce_high", ce, 1);
        check("a77_locked", locked, 1);
        run = 1'b0;
        step();
        check("stop_ce", ce, 0);
        check("stop_locked", locked, 0);
        step();
        step();
        run = 1'b1;
        step();
        check("restart_ce", ce, 1);
        check("restart_locked", locked, 0);

        // Request held high: one ack only; short drop gives a second ack
        cfg_mul = 8'd7; cfg_div = 8'd7; cfg_req = 1'b1;
        n_acks = 0;
        for (int j = 0; j < 10; j++) begin step(); if (cfg_ack === 1'b1) n_acks++; end
        check("held_req_acks", n_acks, 1);
        cfg_req = 1'b0;
        step();
        cfg_req = 1'b1;
        n_acks = 0;
        for (int j = 0; j < 6; j++) begin step(); if (cfg_ack === 1'b1) n_acks++; end
        check("rereq_acks", n_acks, 1);
        cfg_req = 1'b0;
        step();

        // Reset while in CHECK: no ack, defaults restored
        cfg_mul = 8'd2; cfg_div = 8'd3; cfg_req = 1'b1;
        step();
        RST = 1'b1;
        run = 1'b0;
        step();
        RST = 1'b0;
        cfg_req = 1'b0;
        n_acks = 0;
        for (int j = 0; j < 5; j++) begin step(); if (cfg_ack === 1'b1) n_acks++; end
        check("rst_check_acks", n_acks, 0);
        check_default_pattern();

        // Apply 3/8 coincident with an overflow (7/7 overflows every cycle)
        do_cfg(8'd7, 8'd7, got_err, lat);
        cfg_mul = 8'd3; cfg_div = 8'd8; cfg_req = 1'b1;
        step();
        check("a38_pre_ce", ce, 1);
        step();
        cfg_req = 1'b0;
        check("a38_apply_ack", cfg_ack, 1);
        check("a38_apply_ce", ce, 0);
        step();
        check("a38_step1_ce", ce, 0);
        step();
        check("a38_step2_ce", ce, 0);
        step();
        check("a38_step3_ce", ce, 1);

        // Random phase against the model
        seen_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 15) != 0);
            RST = ($urandom_range(0, 799) == 0);
            if (!cfg_req) begin
                cfg_mul = 8'($urandom);
                cfg_div = 8'($urandom);
                if ($urandom_range(0, 39) == 0) begin
                    d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(1, 12));
                    m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(1, (d == 0) ? 1 : d));
                    cfg_mul = 8'(m);
                    cfg_div = 8'(d);
                    cfg_req = 1'b1;
                    seen_ack = 1'b0;
                end
            end else if (seen_ack && ($urandom_range(0, 1) == 1)) begin
                cfg_req = 1'b0;
            end
            step();
            if (cfg_ack === 1'b1) seen_ack = 1'b1;
        end
        RST = 1'b0;
        cfg_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
